// File: rtl/gpr_mp.sv
// Multi-port general register file with dual write-back, bypass and a
// per-register pending scoreboard for load-use stalls.
module gpr_mp #(
  parameter int REG_ADD_WIDTH = 5,
  parameter int REG_DAT_WIDTH = 32,
  parameter int REG_NUM       = 32,
  parameter int RD_PORTS      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [RD_PORTS*REG_ADD_WIDTH-1:0] rd_addr_i,
  output logic [RD_PORTS*REG_DAT_WIDTH-1:0] rd_data_o,
  output logic [RD_PORTS-1:0]               rd_busy_o,
  input  logic                              wre0_i,
  input  logic [REG_ADD_WIDTH-1:0]          wr_addr0_i,
  input  logic [REG_DAT_WIDTH-1:0]          wr_data0_i,
  input  logic                              wre1_i,
  input  logic [REG_ADD_WIDTH-1:0]          wr_addr1_i,
  input  logic [REG_DAT_WIDTH-1:0]          wr_data1_i,
  input  logic                              resv_i,
  input  logic [REG_ADD_WIDTH-1:0]          resv_addr_i,
  input  logic                              flush_i,
  output logic [REG_NUM-1:0]                busy_o
);

  localparam int AW = REG_ADD_WIDTH;
  localparam int DW = REG_DAT_WIDTH;

  logic [DW-1:0]      r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_we0;
  logic [REG_NUM-1:0] w_we1;
  logic [REG_NUM-1:0] w_set;

  // Implemented and writable: in range and not the hardwired zero.
  function automatic logic f_ok(input logic [AW-1:0] a);
    return (32'(a) < REG_NUM) && !(ZERO_REG != 0 && a == '0);
  endfunction

  always_comb begin
    w_we0 = '0;
    w_we1 = '0;
    w_set = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      w_we0[i] = wre0_i && (wr_addr0_i == AW'(i))
                 && f_ok(AW'(i));
      w_we1[i] = wre1_i && (wr_addr1_i == AW'(i))
                 && f_ok(AW'(i));
      w_set[i] = resv_i && (resv_addr_i == AW'(i))
                 && f_ok(AW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_we0[i])
          r_regs[i] <= wr_data0_i;
        else if (w_we1[i])
          r_regs[i] <= wr_data1_i;
      end
    end
  end

  // A new reservation outranks the returning load it replaces.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_set[i])
          r_busy[i] <= 1'b1;
        else if (w_we1[i])
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign busy_o = r_busy;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_q;
    logic          w_b;
    logic          w_ok;
    logic          w_hit0;
    logic          w_hit1;

    assign w_ra   = rd_addr_i[k*AW +: AW];
    assign w_ok   = f_ok(w_ra);
    assign w_hit0 = wre0_i && (wr_addr0_i == w_ra);
    assign w_hit1 = wre1_i && (wr_addr1_i == w_ra);

    always_comb begin
      w_q = '0;
      w_b = 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_ra == AW'(i)) begin
          w_q = r_regs[i];
          w_b = r_busy[i];
        end
      end
    end

    assign rd_data_o[k*DW +: DW] =
      !w_ok  ? '0 :
      w_hit0 ? wr_data0_i :
      w_hit1 ? wr_data1_i : w_q;

    assign rd_busy_o[k] = w_ok && w_b && !w_hit1;
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Next-generation general register file for the CPU core, replacing the fixed 2-read/1-write register group.
- Adds a parametrised number of read ports, a second write port for the load/memory write-back path, and an optional hardwired-zero register 0.
- Adds a per-register pending ("busy") scoreboard so decode can stall on load-use hazards.
- Sits between decode (read and reserve) and the ALU and memory write-back stages.

Parameters:
REG_ADD_WIDTH, 5, register address width
REG_DAT_WIDTH, 32, register data width
REG_NUM, 32, number of implemented registers (must be <= 2**REG_ADD_WIDTH)
RD_PORTS, 2, number of read ports (1..4)
ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
rd_addr_i  in  RD_PORTS*REG_ADD_WIDTH  packed read addresses, port k at bits [k*AW +: AW]
rd_data_o  out  RD_PORTS*REG_DAT_WIDTH  packed read data, combinational
rd_busy_o  out  RD_PORTS  per read port: addressed register is pending
wre0_i  in  1  write enable, ALU write-back port
wr_addr0_i  in  REG_ADD_WIDTH  write address, port 0
wr_data0_i  in  REG_DAT_WIDTH  write data, port 0
wre1_i  in  1  write enable, load write-back port
wr_addr1_i  in  REG_ADD_WIDTH  write address, port 1
wr_data1_i  in  REG_DAT_WIDTH  write data, port 1
resv_i  in  1  reserve request from decode for an issued load
resv_addr_i  in  REG_ADD_WIDTH  destination register to reserve
flush_i  in  1  pipeline flush, clears all reservations
busy_o  out  REG_NUM  full scoreboard vector, registered

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All registers go to 0 and all busy bits go to 0.
  - rst_i takes precedence over every other input in that cycle.
  - After reset, rd_data_o is all 0 and rd_busy_o is all 0.
- Writes:
  - Registers update on the rising edge when the corresponding wre is high.
  - Both ports may write different addresses in the same cycle.
  - Same address on both ports: port 0 wins and port 1 data is dropped.
- Reads are combinational, with write-through bypass:
  - If wre0_i and wr_addr0_i matches the read address, return wr_data0_i.
  - Else if wre1_i and wr_addr1_i matches, return wr_data1_i.
  - Else return the stored value.
- ZERO_REG=1, register 0:
  - Always reads 0, bypass included.
  - Writes to it are discarded.
  - resv_i to address 0 is ignored; busy_o[0] is constant 0.
- Out-of-range addresses (>= REG_NUM):
  - Reads return 0 with busy 0.
  - Writes and reservations are ignored with no side effect.
- Scoreboard, per register r, next-state priority (highest first):
  - rst_i -> 0
  - flush_i -> 0
  - resv_i and resv_addr_i==r -> 1
  - wre1_i and wr_addr1_i==r -> 0
  - otherwise hold
- Consequences of that priority:
  - Reserve and load write-back to the same register in one cycle leave it busy, because the new load owns it.
  - Port 0 writes do not clear busy bits.
- rd_busy_o[k] = busy[rd_addr k] AND NOT (wre1_i AND wr_addr1_i == rd_addr k).
  - This is a same-cycle clear bypass, so decode need not stall on the cycle the load data returns.
- Latency:
  - Write visible on read ports in the same cycle (bypass) and stored at the next edge.
  - A reservation is visible on busy_o and rd_busy_o from the next cycle.
- No internal state machine beyond the register array and busy vector. All arithmetic is equality compare only.

Test Plan:
- Reset then read: rst_i=1 for 2 cycles with random write/reserve inputs -> all rd_data_o=0, busy_o=0 after release.
- Write then read: write 0xDEADBEEF to r5 via port 0.
  - rd_addr0=5 in the write cycle -> bypass returns 0xDEADBEEF.
  - Next cycle -> stored 0xDEADBEEF.
  - Write to r0 with ZERO_REG=1 -> reads 0.
- Dual-write conflict: wre0 r7=0x11 and wre1 r7=0x22 same cycle -> bypass and stored value both 0x11. Port 1 write to r8=0x33 in the same cycle is stored.
- Load-use hazard:
  - resv r9 at cycle t -> busy_o[9]=1 at t+1 and rd_busy_o=1 for rd_addr=9.
  - wre1 r9=0x55 at t+3 -> rd_busy_o=0 and rd_data=0x55 combinationally at t+3; busy_o[9]=0 at t+4.
- Simultaneous events:
  - resv r4 and wre1 r4 same cycle -> busy[4]=1 next cycle.
  - resv r4 with flush_i=1 -> busy_o all 0 next cycle.
  - resv r0 -> busy_o[0] stays 0.
- Parameter sweep: RD_PORTS=4, REG_NUM=16.
  - Read addresses 3, 15, 16, 31 -> correct values for 3 and 15; 0 with busy 0 for 16 and 31.
  - Writes to 20 leave the array unchanged.
